// File: rtl/par_to_ser_feeder.sv
// par_to_ser_feeder: parallel-to-serial word feeder, MSB first.
// A one-word holding register lets the next word be accepted while the
// current one is shifting, so consecutive words stream with no gap.
module par_to_ser_feeder #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] parIn,
   input  logic         load,
   output logic         ready,
   output logic         serOut,
   output logic         en,
   output logic         wordDone
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t          state, state_n;
   logic [N-1:0]    sh, sh_n;
   logic [N-1:0]    hold, hold_n;
   logic            hold_valid, hold_valid_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            accept;

   assign accept = load & ~hold_valid;

   // Outputs are decoded straight from registers.
   assign serOut   = sh[N-1];
   assign en       = (state == SHIFT);
   assign ready    = ~hold_valid;
   assign wordDone = (state == SHIFT) && (cnt == LAST);

   // State register with synchronous reset taking priority over load.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sh         <= '0;
         hold       <= '0;
         hold_valid <= 1'b0;
         cnt        <= '0;
      end else begin
         state      <= state_n;
         sh         <= sh_n;
         hold       <= hold_n;
         hold_valid <= hold_valid_n;
         cnt        <= cnt_n;
      end
   end

   // Next-state logic: shift, refill from hold or parIn at the last bit.
   always_comb begin
      state_n      = state;
      sh_n         = sh;
      hold_n       = hold;
      hold_valid_n = hold_valid;
      cnt_n        = cnt;
      unique case (state)
         IDLE: begin
            if (accept) begin
               sh_n    = parIn;
               cnt_n   = '0;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt != LAST) begin
               sh_n  = {sh[N-2:0], 1'b0};
               cnt_n = cnt + 1'b1;
               if (accept) begin
                  hold_n       = parIn;
                  hold_valid_n = 1'b1;
               end
            end else if (hold_valid) begin
               // Held word goes out next; hold refills only if a load lands now.
               sh_n  = hold;
               cnt_n = '0;
               if (accept) begin
                  hold_n       = parIn;
                  hold_valid_n = 1'b1;
               end else begin
                  hold_valid_n = 1'b0;
               end
            end else if (accept) begin
               sh_n  = parIn;
               cnt_n = '0;
            end else begin
               sh_n    = '0;
               cnt_n   = '0;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_par_to_ser_feeder.sv
// Directed bench for par_to_ser_feeder at N=8 and N=4.
// Inputs are driven and outputs observed on the falling edge.
module tb_par_to_ser_feeder;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [7:0] par_in;
   logic       ready, ser_out, en, word_done;
   logic       load4;
   logic [3:0] par_in4;
   logic       ready4, ser_out4, en4, word_done4;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   par_to_ser_feeder #(.N(8)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .parIn    (par_in),
      .load     (load),
      .ready    (ready),
      .serOut   (ser_out),
      .en       (en),
      .wordDone (word_done)
   );

   par_to_ser_feeder #(.N(4)) u_dut4 (
      .clk      (clk),
      .rst      (rst),
      .parIn    (par_in4),
      .load     (load4),
      .ready    (ready4),
      .serOut   (ser_out4),
      .en       (en4),
      .wordDone (word_done4)
   );

   // Reset state for both widths, load ignored while rst is high.
   task automatic test_reset();
      logic [3:0] obs;
      rst = 1'b1; load = 1'b1; par_in = 8'hFF; load4 = 1'b1; par_in4 = 4'hF;
      @(negedge clk);
      @(negedge clk);
      obs = {en, ser_out, word_done, ready};
      tests_run++;
      if (obs !== 4'b0001) begin
         tests_failed++;
         $display("FAIL reset_n8 {en,ser,wd,rdy} got=%b exp=%b", obs, 4'b0001);
      end
      obs = {en4, ser_out4, word_done4, ready4};
      tests_run++;
      if (obs !== 4'b0001) begin
         tests_failed++;
         $display("FAIL reset_n4 {en,ser,wd,rdy} got=%b exp=%b", obs, 4'b0001);
      end
      rst = 1'b0; load = 1'b0; load4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      obs = {en, ser_out, word_done, ready};
      tests_run++;
      if (obs !== 4'b0001) begin
         tests_failed++;
         $display("FAIL idle_hold {en,ser,wd,rdy} got=%b exp=%b", obs, 4'b0001);
      end
   endtask

   // Single word 8'h9E: eight bits MSB first, wordDone on the last.
   task automatic test_single_word();
      logic [7:0] word;
      logic [2:0] obs, exp;
      word = 8'h9E;
      load = 1'b1; par_in = word;
      @(negedge clk);
      load = 1'b0; par_in = 8'h00;
      for (int i = 0; i < 8; i++) begin
         obs = {en, ser_out, word_done};
         exp = {1'b1, word[7-i], 1'(i == 7)};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL single_word cyc=%0d {en,ser,wd} got=%b exp=%b", i, obs, exp);
         end
         @(negedge clk);
      end
      tests_run++;
      if ({en, word_done, ready} !== 3'b001) begin
         tests_failed++;
         $display("FAIL single_word_end {en,wd,rdy} got=%b exp=%b", {en, word_done, ready}, 3'b001);
      end
   endtask

   // F0 then 0F on the next cycle: 16 contiguous bits, ready low while held.
   task automatic test_back_to_back();
      logic [15:0] stream;
      logic [2:0]  obs, exp;
      logic        exp_rdy;
      stream = {8'hF0, 8'h0F};
      load = 1'b1; par_in = 8'hF0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         obs = {en, ser_out, word_done};
         exp = {1'b1, stream[15-i], 1'(i == 7 || i == 15)};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL back_to_back cyc=%0d {en,ser,wd} got=%b exp=%b", i, obs, exp);
         end
         exp_rdy = (i == 0) || (i >= 8);
         tests_run++;
         if (ready !== exp_rdy) begin
            tests_failed++;
            $display("FAIL back_to_back_ready cyc=%0d got=%b exp=%b", i, ready, exp_rdy);
         end
         load = (i == 0); par_in = 8'h0F;
         @(negedge clk);
      end
      tests_run++;
      if ({en, ready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL back_to_back_end {en,rdy} got=%b exp=%b", {en, ready}, 2'b01);
      end
   endtask

   // Hold full: extra load of 8'h55 must be dropped.
   task automatic test_overflow();
      logic [15:0] stream;
      logic [2:0]  obs, exp;
      stream = {8'hA5, 8'h3C};
      load = 1'b1; par_in = 8'hA5;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         obs = {en, ser_out, word_done};
         exp = {1'b1, stream[15-i], 1'(i == 7 || i == 15)};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL overflow cyc=%0d {en,ser,wd} got=%b exp=%b", i, obs, exp);
         end
         if (i >= 1 && i <= 3) begin
            tests_run++;
            if (ready !== 1'b0) begin
               tests_failed++;
               $display("FAIL overflow_ready cyc=%0d got=%b exp=%b", i, ready, 1'b0);
            end
         end
         load   = (i <= 3);
         par_in = (i == 0) ? 8'h3C : 8'h55;
         @(negedge clk);
      end
      for (int j = 0; j < 3; j++) begin
         tests_run++;
         if ({en, ser_out} !== 2'b00) begin
            tests_failed++;
            $display("FAIL overflow_tail cyc=%0d {en,ser} got=%b exp=%b", j, {en, ser_out}, 2'b00);
         end
         @(negedge clk);
      end
   endtask

   // Load of 8'hC3 exactly at the last-bit edge of 8'h81 with hold empty.
   task automatic test_last_edge_load();
      logic [15:0] stream;
      logic [2:0]  obs, exp;
      stream = {8'h81, 8'hC3};
      load = 1'b1; par_in = 8'h81;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         obs = {en, ser_out, word_done};
         exp = {1'b1, stream[15-i], 1'(i == 7 || i == 15)};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL last_edge cyc=%0d {en,ser,wd} got=%b exp=%b", i, obs, exp);
         end
         load = (i == 7); par_in = 8'hC3;
         @(negedge clk);
      end
      tests_run++;
      if ({en, ready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL last_edge_end {en,rdy} got=%b exp=%b", {en, ready}, 2'b01);
      end
   endtask

   // Reset during bit 4 of 8'hFF, then a clean 8'hAA.
   task automatic test_reset_mid_word();
      logic [7:0] word;
      logic [3:0] obs4;
      logic [2:0] obs, exp;
      load = 1'b1; par_in = 8'hFF;
      @(negedge clk);
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         obs = {en, ser_out, word_done};
         tests_run++;
         if (obs !== 3'b110) begin
            tests_failed++;
            $display("FAIL rst_mid_pre cyc=%0d {en,ser,wd} got=%b exp=%b", i, obs, 3'b110);
         end
         if (i == 3) begin
            rst = 1'b1; load = 1'b1; par_in = 8'hAA;
         end
         @(negedge clk);
      end
      for (int k = 0; k < 2; k++) begin
         obs4 = {en, ser_out, word_done, ready};
         tests_run++;
         if (obs4 !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rst_mid_hold cyc=%0d {en,ser,wd,rdy} got=%b exp=%b", k, obs4, 4'b0001);
         end
         @(negedge clk);
      end
      rst = 1'b0; load = 1'b0;
      @(negedge clk);
      obs4 = {en, ser_out, word_done, ready};
      tests_run++;
      if (obs4 !== 4'b0001) begin
         tests_failed++;
         $display("FAIL rst_mid_idle {en,ser,wd,rdy} got=%b exp=%b", obs4, 4'b0001);
      end
      word = 8'hAA;
      load = 1'b1; par_in = word;
      @(negedge clk);
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         obs = {en, ser_out, word_done};
         exp = {1'b1, word[7-i], 1'(i == 7)};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL rst_mid_after cyc=%0d {en,ser,wd} got=%b exp=%b", i, obs, exp);
         end
         @(negedge clk);
      end
      tests_run++;
      if (en !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_end en got=%b exp=%b", en, 1'b0);
      end
   endtask

   // N=4 instance: 4'b1101 shifts out in four cycles.
   task automatic test_param_n4();
      logic [3:0] word;
      logic [2:0] obs, exp;
      word = 4'b1101;
      load4 = 1'b1; par_in4 = word;
      @(negedge clk);
      load4 = 1'b0; par_in4 = 4'h0;
      for (int i = 0; i < 4; i++) begin
         obs = {en4, ser_out4, word_done4};
         exp = {1'b1, word[3-i], 1'(i == 3)};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL param_n4 cyc=%0d {en,ser,wd} got=%b exp=%b", i, obs, exp);
         end
         @(negedge clk);
      end
      tests_run++;
      if ({en4, ready4} !== 2'b01) begin
         tests_failed++;
         $display("FAIL param_n4_end {en,rdy} got=%b exp=%b", {en4, ready4}, 2'b01);
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; par_in = '0; load4 = 1'b0; par_in4 = '0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_overflow();
      test_last_edge_load();
      test_reset_mid_word();
      test_param_n4();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/par_to_ser_feeder.md
PAR_TO_SER_FEEDER -- requirements
Module: par_to_ser_feeder

Interface
REQ-001 The block SHALL have one parameter: N, default 8, the word width in bits (N >= 2).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  reset, synchronous to clk and active-high.
REQ-005 Port parIn  input  N  parallel word to serialize; sampled only on an accepted load.
REQ-006 Port load  input  1  request to accept parIn; accepted when load=1 and ready=1 at a rising edge.
REQ-007 Port ready  output  1  block can accept a word this cycle.
REQ-008 Port serOut  output  1  serial data bit, MSB first; feeds the detector's serIn.
REQ-009 Port en  output  1  serOut is a valid bit this cycle; feeds the detector's en.
REQ-010 Port wordDone  output  1  high during the cycle that presents bit 0 of a word.

Function
REQ-011 The block SHALL contain the following storage:
- shift register sh[N-1:0];
- holding register hold[N-1:0] with flag holdValid;
- bit counter cnt of width ceil(log2 N);
- state register with states IDLE and SHIFT.
REQ-012 Outputs SHALL be decoded from registers only:
- serOut = sh[N-1];
- en = (state==SHIFT);
- ready = ~holdValid;
- wordDone = en && (cnt==N-1).
REQ-013 In IDLE, an accepted load SHALL load parIn into sh, clear cnt and enter SHIFT, so bit N-1 appears on serOut with en=1 in the next cycle (latency 1).
REQ-014 In IDLE with no accepted load, the block SHALL hold all registers.
REQ-015 In SHIFT with cnt<N-1, each edge SHALL shift sh left by one (zero fill) and increment cnt.
REQ-016 In SHIFT with cnt<N-1, an accepted load SHALL write parIn to hold and set holdValid.
REQ-017 In SHIFT with cnt==N-1 (last-bit edge), the next word SHALL be chosen in this priority:
- (a) if holdValid, sh<=hold and cnt<=0, stay in SHIFT, and holdValid clears unless a load is accepted at the same edge, in which case hold<=parIn and holdValid stays 1;
- (b) else, if a load is accepted, sh<=parIn and cnt<=0, stay in SHIFT;
- (c) otherwise go to IDLE with sh<=0 and cnt<=0.
REQ-018 Consecutive words SHALL stream with no idle cycle between the last bit of one word and the first bit of the next.
REQ-019 A load while ready=0 SHALL be ignored: parIn is not sampled and no state changes because of it.
REQ-020 Each accepted word SHALL produce exactly N consecutive en=1 cycles, each bit emitted exactly once, in order N-1 down to 0.
REQ-021 cnt SHALL never exceed N-1; it wraps to 0 only through REQ-017.

Reset
REQ-022 When rst=1 at a rising edge, the block SHALL set:
- state=IDLE;
- sh=0, hold=0, holdValid=0, cnt=0.
The outputs after that edge SHALL then be serOut=0, en=0, ready=1, wordDone=0.
REQ-023 rst SHALL take priority over load at the same edge, and a word in flight or held SHALL be discarded without further bits.
REQ-024 While rst stays high, the outputs SHALL stay at their reset values regardless of load.

Verification
REQ-025 Single word (N=8): after reset, load=1 for one cycle with parIn=8'h9E -> en=1 for exactly 8 cycles, serOut=1,0,0,1,1,1,1,0, wordDone only on the 8th cycle, then en=0.
REQ-026 Back-to-back: load 8'hF0, then 8'h0F on the next cycle -> 16 contiguous en=1 cycles with serOut=11110000 00001111, wordDone on cycles 8 and 16, ready=0 from the cycle after the second load until hold empties.
REQ-027 Overflow: with hold full, present a third load of 8'h55 -> ready=0 and the load is ignored; the stream contains only the two accepted words and en=0 afterwards.
REQ-028 Last-edge load with hold empty: load 8'hC3 exactly at the last-bit edge of 8'h81 -> en stays 1 with no gap, serOut continues 11000011.
REQ-029 Reset mid-word: assert rst during bit 4 of 8'hFF -> next cycle en=0, serOut=0, ready=1, wordDone=0; a later load of 8'hAA streams 10101010 cleanly.
REQ-030 Parameter check (N=4): load 4'b1101 -> en=1 for 4 cycles, serOut=1,1,0,1, wordDone on the 4th cycle.
